// File: rtl/pci_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pci_pkg
// Description : Shared PCI definitions: bus command codes, byte-enable
//               patterns, the MSI master state encoding and the PCI parity
//               function used by every block that drives AD/C/BE#.
// Revision    : 1.0 - initial release
// ============================================================================
package pci_pkg;

    // Bus commands as driven on C/BE# during an address phase
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
    localparam logic [3:0] CMD_DAC       = 4'b1101;

    // Byte-enable patterns for data phases / idle bus
    localparam logic [3:0] CBE_ALL_BYTES = 4'b0000;
    localparam logic [3:0] CBE_IDLE      = 4'b1111;

    // MSI master states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_ADDR_HI = 3'd3,
        ST_DATA    = 3'd4,
        ST_TURN    = 3'd5
    } msi_state_e;

    // PCI PAR covers AD[31:0] and C/BE#[3:0] (even parity over 36 bits)
    function automatic logic pci_parity(input logic [31:0] ad, input logic [3:0] cbe);
        return ^{ad, cbe};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pci_msi_master_if.sv
`default_nettype none
// ============================================================================
// Module      : pci_msi_master_if
// Description : PCI initiator-side bus bundle between the MSI master and the
//               shared pad drivers / arbiter.
//               master modport : the MSI master (drives REQ#, FRAME#, IRDY#,
//                                AD, C/BE#, PAR and their enables)
//               slave modport  : the bus side (arbiter grant, sampled
//                                FRAME#/IRDY#, target responses)
// Revision    : 1.0 - initial release
// ============================================================================
interface pci_msi_master_if;

    // bus -> master
    logic        gnt_n;
    logic        frame_n_i;
    logic        irdy_n_i;
    logic        trdy_n_i;
    logic        devsel_n_i;
    logic        stop_n_i;

    // master -> bus
    logic        req_n;
    logic        frame_n_o;
    logic        irdy_n_o;
    logic        ctl_oe;
    logic [31:0] ad_o;
    logic [3:0]  cbe_n_o;
    logic        ad_oe;
    logic        par_o;
    logic        par_oe;

    modport master (
        input  gnt_n, frame_n_i, irdy_n_i, trdy_n_i, devsel_n_i, stop_n_i,
        output req_n, frame_n_o, irdy_n_o, ctl_oe, ad_o, cbe_n_o, ad_oe,
               par_o, par_oe
    );

    modport slave (
        output gnt_n, frame_n_i, irdy_n_i, trdy_n_i, devsel_n_i, stop_n_i,
        input  req_n, frame_n_o, irdy_n_o, ctl_oe, ad_o, cbe_n_o, ad_oe,
               par_o, par_oe
    );

endinterface
`default_nettype wire

// File: rtl/pci_par_gen.sv
`default_nettype none
// ============================================================================
// Module      : pci_par_gen
// Description : PCI parity generator. PAR lags AD/C/BE# by one clock, so
//               both the parity bit and its output enable are registered
//               copies of the previous cycle's AD/C/BE# and AD enable.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_ad, i_cbe     - AD and C/BE# being driven this cycle
//               i_oe            - AD/C/BE# output enable this cycle
//               o_par, o_par_oe - PAR and its enable for the next cycle
// Revision    : 1.0 - initial release
// ============================================================================
module pci_par_gen
    import pci_pkg::*;
(
    input  wire         clk,
    input  wire         rst,
    input  wire  [31:0] i_ad,
    input  wire  [3:0]  i_cbe,
    input  wire         i_oe,
    output logic        o_par,
    output logic        o_par_oe
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_par    <= 1'b0;
            o_par_oe <= 1'b0;
        end else begin
            o_par    <= pci_parity(i_ad, i_cbe);
            o_par_oe <= i_oe;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pci_msi_master.sv
`default_nettype none
// ============================================================================
// Module      : pci_msi_master
// Description : PCI bus-master initiator that delivers MSI messages as
//               single-DWORD Memory Write transactions, with optional
//               dual-address cycle, target retry handling and master/target
//               abort reporting.
// Ports       : clk, rst            - PCI clock, synchronous active-high reset
//               msi_req             - one-cycle MSI request pulse
//               msi_enable          - MSI Enable from config space
//               bus_master_en       - Command register Bus Master bit
//               msi_address[61:0]   - message address bits [63:2]
//               msi_data[15:0]      - message data
//               bus                 - PCI initiator bundle (master modport)
//               msi_busy            - message pending or in flight
//               received_master_abort / received_target_abort - status pulses
// Revision    : 1.0 - initial release
// ============================================================================
module pci_msi_master
    import pci_pkg::*;
#(
    parameter int DEVSEL_TIMEOUT = 5,
    parameter int RETRY_LIMIT    = 16
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire                  msi_req,
    input  wire                  msi_enable,
    input  wire                  bus_master_en,
    input  wire  [61:0]          msi_address,
    input  wire  [15:0]          msi_data,
    pci_msi_master_if.master     bus,
    output logic                 msi_busy,
    output logic                 received_master_abort,
    output logic                 received_target_abort
);

    // Last DATA cycle index (counted from 0) at which DEVSEL# may still arrive
    localparam logic [7:0]  c_devsel_last   = 8'(DEVSEL_TIMEOUT - 1);
    localparam logic [15:0] c_retry_limit   = 16'(RETRY_LIMIT);
    localparam bit          c_retry_bounded = (RETRY_LIMIT != 0);

    msi_state_e  r_state;
    msi_state_e  w_next;

    logic        r_pending;
    logic [61:0] r_addr;
    logic [15:0] r_data;
    logic        r_dac;
    logic [7:0]  r_cnt;
    logic        r_devsel_seen;
    logic [15:0] r_retry_cnt;
    logic        r_master_abort;
    logic        r_target_abort;

    logic        w_accept;
    logic        w_bus_idle;
    logic        w_start;
    logic        w_success;
    logic        w_retry;
    logic        w_tabort;
    logic        w_mabort;
    logic        w_retry_drop;

    logic        w_req_n;
    logic        w_frame_n;
    logic        w_irdy_n;
    logic        w_ctl_oe;
    logic [31:0] w_ad;
    logic [3:0]  w_cbe_n;
    logic        w_ad_oe;
    logic        w_par;
    logic        w_par_oe;

    // ------------------------------------------------------------------------
    // Request qualification and target-response decode
    // ------------------------------------------------------------------------
    assign w_accept   = msi_req & msi_enable & bus_master_en;
    assign w_bus_idle = bus.frame_n_i & bus.irdy_n_i;
    assign w_start    = (r_state == ST_REQ) && (w_next == ST_ADDR);

    assign w_success  = ~bus.trdy_n_i & ~bus.devsel_n_i;
    assign w_retry    = ~bus.stop_n_i &  bus.trdy_n_i & ~bus.devsel_n_i;
    // Target abort is STOP# with DEVSEL# withdrawn after it had been claimed
    assign w_tabort   = ~bus.stop_n_i &  bus.devsel_n_i & r_devsel_seen;
    assign w_mabort   =  bus.devsel_n_i & ~r_devsel_seen & (r_cnt == c_devsel_last);

    assign w_retry_drop = c_retry_bounded && ((r_retry_cnt + 16'd1) == c_retry_limit);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and bus outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_req_n   = 1'b1;
        w_frame_n = 1'b1;
        w_irdy_n  = 1'b1;
        w_ctl_oe  = 1'b0;
        w_ad_oe   = 1'b0;
        w_ad      = 32'h0;
        w_cbe_n   = CBE_IDLE;

        case (r_state)
            ST_IDLE: begin
                // A same-cycle request bypasses the pending flag so REQ#
                // follows msi_req by a single clock
                if ((r_pending || w_accept) && bus_master_en) begin
                    w_next = ST_REQ;
                end
            end

            ST_REQ: begin
                w_req_n = 1'b0;
                if (!bus_master_en) begin
                    w_next = ST_IDLE;
                end else if (!bus.gnt_n && w_bus_idle) begin
                    w_next = ST_ADDR;
                end
            end

            ST_ADDR: begin
                w_frame_n = 1'b0;
                w_ctl_oe  = 1'b1;
                w_ad_oe   = 1'b1;
                w_ad      = {r_addr[29:0], 2'b00};
                w_cbe_n   = r_dac ? CMD_DAC : CMD_MEM_WRITE;
                w_next    = r_dac ? ST_ADDR_HI : ST_DATA;
            end

            ST_ADDR_HI: begin
                w_frame_n = 1'b0;
                w_ctl_oe  = 1'b1;
                w_ad_oe   = 1'b1;
                w_ad      = r_addr[61:30];
                w_cbe_n   = CMD_MEM_WRITE;
                w_next    = ST_DATA;
            end

            ST_DATA: begin
                // Single-DWORD burst: FRAME# is released with IRDY# asserted
                w_irdy_n = 1'b0;
                w_ctl_oe = 1'b1;
                w_ad_oe  = 1'b1;
                w_ad     = {16'h0, r_data};
                w_cbe_n  = CBE_ALL_BYTES;
                if (w_success || w_retry || w_tabort || w_mabort) begin
                    w_next = ST_TURN;
                end
            end

            ST_TURN: begin
                // Drive FRAME#/IRDY# high for one clock before tri-stating
                w_ctl_oe = 1'b1;
                w_next   = ST_IDLE;
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pending flag, message latches, DEVSEL timer, retry counter, pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending      <= 1'b0;
            r_addr         <= 62'h0;
            r_data         <= 16'h0;
            r_dac          <= 1'b0;
            r_cnt          <= 8'h0;
            r_devsel_seen  <= 1'b0;
            r_retry_cnt    <= 16'h0;
            r_master_abort <= 1'b0;
            r_target_abort <= 1'b0;
        end else begin
            r_master_abort <= 1'b0;
            r_target_abort <= 1'b0;

            if (w_start) begin
                r_pending <= 1'b0;
                r_addr    <= msi_address;
                r_data    <= msi_data;
                r_dac     <= |msi_address[61:30];
            end

            if ((r_state == ST_ADDR) || (r_state == ST_ADDR_HI)) begin
                r_cnt         <= 8'h0;
                r_devsel_seen <= 1'b0;
            end

            if (r_state == ST_DATA) begin
                r_cnt <= r_cnt + 8'd1;
                if (!bus.devsel_n_i) begin
                    r_devsel_seen <= 1'b1;
                end

                if (w_success) begin
                    r_retry_cnt <= 16'h0;
                end else if (w_retry) begin
                    if (w_retry_drop) begin
                        r_pending   <= 1'b0;
                        r_retry_cnt <= 16'h0;
                    end else begin
                        r_pending   <= 1'b1;
                        r_retry_cnt <= r_retry_cnt + 16'd1;
                    end
                end else if (w_tabort) begin
                    r_target_abort <= 1'b1;
                    r_retry_cnt    <= 16'h0;
                end else if (w_mabort) begin
                    r_master_abort <= 1'b1;
                    r_retry_cnt    <= 16'h0;
                end
            end

            // New requests win over any clear so none is lost; repeated
            // requests simply coalesce into one further message
            if (w_accept) begin
                r_pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Parity
    // ------------------------------------------------------------------------
    pci_par_gen u_par_gen (
        .clk      (clk),
        .rst      (rst),
        .i_ad     (w_ad),
        .i_cbe    (w_cbe_n),
        .i_oe     (w_ad_oe),
        .o_par    (w_par),
        .o_par_oe (w_par_oe)
    );

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.req_n     = w_req_n;
    assign bus.frame_n_o = w_frame_n;
    assign bus.irdy_n_o  = w_irdy_n;
    assign bus.ctl_oe    = w_ctl_oe;
    assign bus.ad_o      = w_ad;
    assign bus.cbe_n_o   = w_cbe_n;
    assign bus.ad_oe     = w_ad_oe;
    assign bus.par_o     = w_par;
    assign bus.par_oe    = w_par_oe;

    assign msi_busy              = r_pending || (r_state != ST_IDLE);
    assign received_master_abort = r_master_abort;
    assign received_target_abort = r_target_abort;

endmodule
`default_nettype wire

// File: tb/tb_pci_msi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pci_msi_master
// Description : Scoreboard bench for pci_msi_master. Stimulus pushes the
//               expected address/data phases; a monitor pops and compares
//               each bus phase and the parity that follows it. A second
//               instance with RETRY_LIMIT=2 exercises message drop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pci_msi_master;

    typedef struct packed {
        logic [31:0] ad;
        logic [3:0]  cbe;
    } phase_t;

    localparam int MODE_OK     = 0;
    localparam int MODE_RETRY  = 1;
    localparam int MODE_NODEV  = 2;
    localparam int MODE_TABORT = 3;
    localparam int MODE_HOLD   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        msi_req, msi_enable, bus_master_en;
    logic [61:0] msi_address;
    logic [15:0] msi_data;
    logic        msi_busy, rma, rta;

    logic        msi_req2, msi_enable2, bus_master_en2;
    logic [61:0] msi_address2;
    logic [15:0] msi_data2;
    logic        msi_busy2, rma2, rta2;

    pci_msi_master_if bus();
    pci_msi_master_if bus2();

    // Sampled FRAME#/IRDY# are the bus wires; only this initiator drives them
    assign bus.frame_n_i  = bus.ctl_oe  ? bus.frame_n_o  : 1'b1;
    assign bus.irdy_n_i   = bus.ctl_oe  ? bus.irdy_n_o   : 1'b1;
    assign bus2.frame_n_i = bus2.ctl_oe ? bus2.frame_n_o : 1'b1;
    assign bus2.irdy_n_i  = bus2.ctl_oe ? bus2.irdy_n_o  : 1'b1;

    pci_msi_master #(.DEVSEL_TIMEOUT(5), .RETRY_LIMIT(16)) u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .msi_req               (msi_req),
        .msi_enable            (msi_enable),
        .bus_master_en         (bus_master_en),
        .msi_address           (msi_address),
        .msi_data              (msi_data),
        .bus                   (bus),
        .msi_busy              (msi_busy),
        .received_master_abort (rma),
        .received_target_abort (rta)
    );

    pci_msi_master #(.DEVSEL_TIMEOUT(5), .RETRY_LIMIT(2)) u_dut2 (
        .clk                   (clk),
        .rst                   (rst),
        .msi_req               (msi_req2),
        .msi_enable            (msi_enable2),
        .bus_master_en         (bus_master_en2),
        .msi_address           (msi_address2),
        .msi_data              (msi_data2),
        .bus                   (bus2),
        .msi_busy              (msi_busy2),
        .received_master_abort (rma2),
        .received_target_abort (rta2)
    );

    int     checks = 0;
    int     errors = 0;
    int     ma_cnt = 0;
    int     ta_cnt = 0;
    int     gnt_delay = 2;
    int     frames2 = 0;
    phase_t exp_q[$];
    int     mode_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected phases of one transaction, built from the message alone
    task automatic push_txn(input logic [63:0] addr, input logic [15:0] data);
        if (addr[63:32] != 32'h0) begin
            exp_q.push_back({addr[31:2], 2'b00, 4'b1101});
            exp_q.push_back({addr[63:32], 4'b0111});
        end else begin
            exp_q.push_back({addr[31:2], 2'b00, 4'b0111});
        end
        exp_q.push_back({16'h0, data, 4'b0000});
    endtask

    task automatic pulse_req(input logic [63:0] addr, input logic [15:0] data);
        msi_address = addr[63:2];
        msi_data    = data;
        @(negedge clk);
        msi_req = 1'b1;
        @(negedge clk);
        msi_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (msi_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy"}, msi_busy, 1'b0);
        check({name, "_queue"}, exp_q.size(), 0);
    endtask

    task automatic wait_data(input string name);
        int n;
        n = 0;
        while (bus.irdy_n_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reach_data"}, bus.irdy_n_o, 1'b0);
    endtask

    // Arbiter: grants gnt_delay cycles after REQ# is seen
    initial begin
        int wcnt;
        wcnt = 0;
        bus.gnt_n = 1'b1;
        forever begin
            @(negedge clk);
            if (!bus.req_n) begin
                wcnt++;
                bus.gnt_n = (wcnt >= gnt_delay) ? 1'b0 : 1'b1;
            end else begin
                wcnt = 0;
                bus.gnt_n = 1'b1;
            end
        end
    end

    // Target: response per transaction taken from mode_q
    initial begin
        int   mode, dcyc;
        logic prev_frame;
        mode = MODE_OK;
        dcyc = 0;
        prev_frame = 1'b1;
        bus.trdy_n_i = 1'b1; bus.devsel_n_i = 1'b1; bus.stop_n_i = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.ctl_oe && !bus.frame_n_o && prev_frame) begin
                mode = (mode_q.size() > 0) ? mode_q.pop_front() : MODE_OK;
                dcyc = 0;
            end
            prev_frame = bus.frame_n_o | ~bus.ctl_oe;
            bus.trdy_n_i = 1'b1; bus.devsel_n_i = 1'b1; bus.stop_n_i = 1'b1;
            if (bus.ctl_oe && !bus.irdy_n_o) begin
                case (mode)
                    MODE_OK:     begin bus.devsel_n_i = 1'b0; bus.trdy_n_i = 1'b0; end
                    MODE_RETRY:  begin bus.devsel_n_i = 1'b0; bus.stop_n_i = 1'b0; end
                    MODE_TABORT: begin
                        if (dcyc == 0) bus.devsel_n_i = 1'b0;
                        else           bus.stop_n_i   = 1'b0;
                    end
                    MODE_HOLD:   bus.devsel_n_i = 1'b0;
                    default:     ;
                endcase
                dcyc++;
            end
        end
    end

    // Second instance: immediate grant, target always retries
    initial begin
        logic prev_frame;
        prev_frame = 1'b1;
        bus2.gnt_n = 1'b1;
        bus2.trdy_n_i = 1'b1; bus2.devsel_n_i = 1'b1; bus2.stop_n_i = 1'b1;
        forever begin
            @(negedge clk);
            bus2.gnt_n = bus2.req_n;
            if (bus2.ctl_oe && !bus2.frame_n_o && prev_frame) frames2++;
            prev_frame = bus2.frame_n_o | ~bus2.ctl_oe;
            bus2.trdy_n_i   = 1'b1;
            bus2.devsel_n_i = (bus2.ctl_oe && !bus2.irdy_n_o) ? 1'b0 : 1'b1;
            bus2.stop_n_i   = (bus2.ctl_oe && !bus2.irdy_n_o) ? 1'b0 : 1'b1;
        end
    end

    // Monitor: phase scoreboard and parity one cycle later
    initial begin
        logic   prev_driven, prev_irdy, exp_par;
        phase_t cur, got;
        prev_driven = 1'b0;
        prev_irdy   = 1'b1;
        exp_par     = 1'b0;
        cur         = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_driven = 1'b0;
                prev_irdy   = 1'b1;
            end else begin
                if (prev_driven) begin
                    check("par_oe", bus.par_oe, 1'b1);
                    check("par_o", bus.par_o, exp_par);
                end else begin
                    check("par_oe_idle", bus.par_oe, 1'b0);
                end
                if (rma) ma_cnt++;
                if (rta) ta_cnt++;
                if (bus.ad_oe) begin
                    got = {bus.ad_o, bus.cbe_n_o};
                    if (!bus.frame_n_o || (!bus.irdy_n_o && prev_irdy)) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_phase actual=%0h required=none", got);
                        end else begin
                            cur = exp_q.pop_front();
                            check("phase", got, cur);
                        end
                    end
                    exp_par = ^{cur.ad, cur.cbe};
                end
                prev_driven = bus.ad_oe;
                prev_irdy   = bus.irdy_n_o;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        msi_req = 1'b0; msi_enable = 1'b1; bus_master_en = 1'b1;
        msi_address = '0; msi_data = '0;
        msi_req2 = 1'b0; msi_enable2 = 1'b1; bus_master_en2 = 1'b1;
        msi_address2 = 62'h3F80_0400; msi_data2 = 16'h0055;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_req_n",  bus.req_n,     1'b1);
        check("rst_frame",  bus.frame_n_o, 1'b1);
        check("rst_irdy",   bus.irdy_n_o,  1'b1);
        check("rst_ctl_oe", bus.ctl_oe,    1'b0);
        check("rst_ad_oe",  bus.ad_oe,     1'b0);
        check("rst_par_oe", bus.par_oe,    1'b0);
        check("rst_ad",     bus.ad_o,      32'h0);
        check("rst_cbe",    bus.cbe_n_o,   4'hF);
        check("rst_par",    bus.par_o,     1'b0);
        check("rst_busy",   msi_busy,      1'b0);
        check("rst_rma",    rma,           1'b0);
        check("rst_rta",    rta,           1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 32-bit delivery
        push_txn(64'hFEE0_1000, 16'h0041);
        mode_q.push_back(MODE_OK);
        pulse_req(64'hFEE0_1000, 16'h0041);
        check("req_latency", bus.req_n, 1'b0);
        wait_idle("w32");
        check("w32_ma", ma_cnt, 0);
        check("w32_ta", ta_cnt, 0);

        // Dual address cycle
        push_txn(64'h1_0000_2000, 16'h1234);
        mode_q.push_back(MODE_OK);
        pulse_req(64'h1_0000_2000, 16'h1234);
        wait_idle("dac");

        // Master abort
        push_txn(64'hFEE0_2004, 16'h0077);
        mode_q.push_back(MODE_NODEV);
        pulse_req(64'hFEE0_2004, 16'h0077);
        wait_idle("mabort");
        check("mabort_pulses", ma_cnt, 1);
        check("mabort_ctl_oe", bus.ctl_oe, 1'b0);
        check("mabort_ad_oe", bus.ad_oe, 1'b0);

        // Target abort
        push_txn(64'hFEE0_3008, 16'h00A5);
        mode_q.push_back(MODE_TABORT);
        pulse_req(64'hFEE0_3008, 16'h00A5);
        wait_idle("tabort");
        check("tabort_pulses", ta_cnt, 1);

        // Three retries then success: four identical transactions
        for (int i = 0; i < 4; i++) push_txn(64'hFEE0_4000, 16'h0101);
        mode_q.push_back(MODE_RETRY);
        mode_q.push_back(MODE_RETRY);
        mode_q.push_back(MODE_RETRY);
        mode_q.push_back(MODE_OK);
        pulse_req(64'hFEE0_4000, 16'h0101);
        wait_idle("retry");
        check("retry_ma", ma_cnt, 1);
        check("retry_ta", ta_cnt, 1);

        // Gating: MSI disabled, then Bus Master disabled
        msi_enable = 1'b0;
        pulse_req(64'hFEE0_5000, 16'h0002);
        for (int i = 0; i < 4; i++) begin
            check("gate_msi_req_n", bus.req_n, 1'b1);
            check("gate_msi_busy", msi_busy, 1'b0);
            @(negedge clk);
        end
        msi_enable = 1'b1;
        bus_master_en = 1'b0;
        pulse_req(64'hFEE0_5000, 16'h0002);
        for (int i = 0; i < 4; i++) begin
            check("gate_bme_req_n", bus.req_n, 1'b1);
            check("gate_bme_busy", msi_busy, 1'b0);
            @(negedge clk);
        end
        bus_master_en = 1'b1;

        // Bus Master dropped while requesting: REQ# released, message kept
        push_txn(64'hFEE0_6000, 16'h0C0C);
        mode_q.push_back(MODE_OK);
        gnt_delay = 50;
        pulse_req(64'hFEE0_6000, 16'h0C0C);
        @(negedge clk);
        bus_master_en = 1'b0;
        @(negedge clk);
        check("bme_drop_req_n", bus.req_n, 1'b1);
        check("bme_drop_busy", msi_busy, 1'b1);
        gnt_delay = 1;
        bus_master_en = 1'b1;
        wait_idle("bme_drop");
        gnt_delay = 2;

        // Request during DATA: exactly one follow-up transaction
        push_txn(64'hFEE0_7000, 16'h0033);
        push_txn(64'hFEE0_7000, 16'h0033);
        mode_q.push_back(MODE_OK);
        mode_q.push_back(MODE_OK);
        pulse_req(64'hFEE0_7000, 16'h0033);
        wait_data("coalesce");
        msi_req = 1'b1;
        @(negedge clk);
        msi_req = 1'b0;
        wait_idle("coalesce");
        repeat (10) @(negedge clk);
        check("coalesce_quiet", exp_q.size(), 0);

        // Reset during DATA
        push_txn(64'hFEE0_8000, 16'h0099);
        mode_q.push_back(MODE_HOLD);
        pulse_req(64'hFEE0_8000, 16'h0099);
        wait_data("rstdata");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstdata_ctl_oe", bus.ctl_oe, 1'b0);
        check("rstdata_ad_oe",  bus.ad_oe,  1'b0);
        check("rstdata_par_oe", bus.par_oe, 1'b0);
        check("rstdata_req_n",  bus.req_n,  1'b1);
        check("rstdata_busy",   msi_busy,   1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rstdata_pending", msi_busy, 1'b0);
        check("rstdata_req_after", bus.req_n, 1'b1);

        // RETRY_LIMIT=2: dropped after two retried transactions
        @(negedge clk);
        msi_req2 = 1'b1;
        @(negedge clk);
        msi_req2 = 1'b0;
        for (int n = 0; n < 200 && msi_busy2; n++) @(negedge clk);
        check("limit2_busy", msi_busy2, 1'b0);
        repeat (10) @(negedge clk);
        check("limit2_frames", frames2, 2);
        check("limit2_busy_after", msi_busy2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pci_msi_master.md
Name: pci_msi_master

Overview:
- PCI bus-master initiator that delivers MSI messages as single-DWORD Memory Write transactions.
- Consumes the MSI address/data/enable and Bus Master Enable state held by the config-space block.
- Reports Received Master Abort and Received Target Abort pulses back to the status register.
- Sits between the interrupt source logic and the shared PCI AD/control pad drivers.

Parameters:
- DEVSEL_TIMEOUT, 5: clocks after the last address phase without DEVSEL# before master abort.
- RETRY_LIMIT, 16: consecutive target retries before the message is dropped; 0 means unlimited.

Ports:
- clk  in  1  PCI clock
- rst  in  1  synchronous reset, active-high
- msi_req  in  1  one-cycle pulse requesting an MSI
- msi_enable  in  1  MSI Enable bit from config space
- bus_master_en  in  1  Command register Bus Master bit
- msi_address  in  62  message address bits [63:2]
- msi_data  in  16  message data
- gnt_n  in  1  arbiter grant, active-low
- frame_n_i, irdy_n_i  in  1  sampled bus FRAME#/IRDY#
- trdy_n_i, devsel_n_i, stop_n_i  in  1  target responses
- req_n  out  1  bus request, active-low
- frame_n_o, irdy_n_o  out  1  initiator controls
- ctl_oe  out  1  output enable for FRAME#/IRDY#
- ad_o  out  32  address/data
- cbe_n_o  out  4  command/byte enables
- ad_oe  out  1  output enable for AD and C/BE#
- par_o, par_oe  out  1  parity and its output enable
- msi_busy  out  1  a message is pending or in flight
- received_master_abort  out  1  one-cycle pulse
- received_target_abort  out  1  one-cycle pulse

Behaviour:
- Reset values (applied at the next clk edge while rst=1, including mid-transaction):
  - req_n=1, frame_n_o=1, irdy_n_o=1.
  - ctl_oe=0, ad_oe=0, par_oe=0.
  - ad_o=0, cbe_n_o=4'hF, par_o=0.
  - pending=0, retry count=0, all pulses 0, state IDLE.
- Pending flag:
  - Set by msi_req only when msi_enable and bus_master_en are both 1; otherwise msi_req is ignored.
  - msi_req during an active transaction sets pending again, so exactly one further message follows; multiple requests coalesce.
  - Cleared when a transaction starts (ADDR).
  - msi_busy = pending or state != IDLE.
- Address and data latching:
  - Address and data are latched at the transition into ADDR.
  - Dual-address-cycle mode (DAC) is selected when msi_address[63:32] != 0.
- States:
  - IDLE:
    - pending=1 -> REQ. req_n=0 in REQ.
  - REQ:
    - If bus_master_en drops, deassert req_n and go to IDLE, keeping pending.
    - Bus idle (frame_n_i=1 and irdy_n_i=1) and gnt_n=0 -> ADDR.
  - ADDR:
    - Drives frame_n_o=0, ctl_oe=1, ad_oe=1, req_n=1.
    - DAC: ad_o = lower address {msi_address[31:2],2'b00}, cbe_n_o=4'b1101 (DAC) -> ADDR_HI.
    - Otherwise: ad_o = the same lower address, cbe_n_o=4'b0111 (Memory Write) -> DATA.
  - ADDR_HI:
    - ad_o = msi_address[63:32], cbe_n_o=4'b0111 -> DATA.
  - DATA:
    - frame_n_o=1, irdy_n_o=0, ad_o={16'h0,msi_data}, cbe_n_o=4'b0000.
    - Count cycles since the last address phase.
    - trdy_n_i=0 and devsel_n_i=0 -> TURN; success; retry count cleared.
    - stop_n_i=0, trdy_n_i=1, devsel_n_i=0 (retry) -> TURN; pending set again; retry count incremented. If count reaches RETRY_LIMIT (nonzero), drop the message and clear pending instead.
    - stop_n_i=0, devsel_n_i=1 after DEVSEL was seen (target abort) -> TURN; received_target_abort pulse; message dropped.
    - No DEVSEL within DEVSEL_TIMEOUT cycles (master abort) -> TURN; received_master_abort pulse; message dropped.
  - TURN:
    - irdy_n_o=1 and ad_oe=0 for one cycle; ctl_oe=1 (drive high).
    - Then -> IDLE with ctl_oe=0.
- Parity:
  - par_o = XOR of the previous cycle's ad_o and cbe_n_o.
  - par_oe = previous cycle's ad_oe. par_oe is therefore asserted exactly one cycle after every driven address/data cycle, including the TURN cycle.
- Bus Master disable mid-transaction: the current transaction completes normally; no new REQ is issued.
- Latency: msi_req to req_n=0 is 1 cycle; grant to FRAME# is 1 cycle.

Decomposition:
- Shared package pci_pkg:
  - PCI command constants (CMD_MEM_WRITE=4'b0111, CMD_DAC=4'b1101).
  - The master state enum.
  - Parity function.
- Sub-module pci_par_gen: one-cycle-delayed parity/output-enable register.
- The config block and future bus-target logic reuse pci_par_gen.

Test Plan:
- 32-bit delivery:
  - Stimulus: msi_address=32'hFEE0_1000, data=16'h0041, gnt after 2 cycles, target DEVSEL+TRDY in the first data cycle.
  - Required: ADDR ad_o=FEE01000 with cbe 0111; DATA ad_o=00000041 with cbe 0000; par_o correct one cycle later; no abort pulses.
- DAC:
  - Stimulus: address 64'h1_0000_2000.
  - Required: two address phases (00002000/1101, then 00000001/0111), then data.
- Master abort:
  - Stimulus: no DEVSEL for 5 cycles.
  - Required: received_master_abort pulses once; bus released; msi_busy=0.
- Retry:
  - Stimulus: STOP# with DEVSEL and no TRDY three times, then TRDY.
  - Required: 4 transactions on the bus, one success, msi_busy falls after the 4th; with RETRY_LIMIT=2 the message is dropped after 2 retries.
- Gating:
  - Stimulus: msi_enable=0 or bus_master_en=0 with msi_req.
  - Required: req_n stays 1.
  - Stimulus: msi_req during DATA.
  - Required: exactly one follow-up transaction.
- Reset mid-DATA:
  - Stimulus: rst=1 for one cycle during DATA.
  - Required: all output enables 0 and req_n=1 at the next edge; pending cleared.
